// File: rtl/nubus_mailbox_slave.sv
// nubus_mailbox_slave: target-side responder for the card's mem_* interface.
// Decodes a 4-register window (DATA, STATUS, CONTROL, SCRATCH) via mem_addr[3:2]
// and holds a DEPTH-word inbound mailbox FIFO that NuBus masters push and local
// logic pops. Each bus request is answered after WAIT_CLOCKS wait cycles with a
// one-cycle mem_ready_o pulse; register side effects commit on the ACK edge.
// Optional build macro: MAILBOX_IRQ_EN adds the irq output and CONTROL[15:8]
// IRQ_THRESH field.
module nubus_mailbox_slave #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned WAIT_CLOCKS  = 1,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
    input  logic                   mem_clk,
    input  logic                   mem_reset,
    input  logic                   mem_valid,
    input  logic [3:0]             mem_write,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    input  logic                   mem_myslot,
    output logic [31:0]            mem_rdata_o,
    output logic                   mem_ready_o,
    input  logic                   loc_pop,
    output logic [31:0]            loc_data,
    output logic                   loc_empty,
    output logic [$clog2(DEPTH):0] loc_count
`ifdef MAILBOX_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Register window decode on mem_addr[3:2]
    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_SCR  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [1:0]    wait_cnt;
    logic [1:0]    wait_cnt_n;

    logic [1:0]    req_addr;
    logic [3:0]    req_strb;
    logic [31:0]   req_wdata;

    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_n;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_n;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          ovf;
    logic          ovf_n;
    logic [31:0]   scratch;
    logic [31:0]   scratch_n;
    logic [31:0]   rdata_d;

`ifdef MAILBOX_IRQ_EN
    logic [7:0]    thresh;
    logic [7:0]    thresh_n;
`endif

    logic          accept;
    logic          commit;
    logic          req_wr;
    logic [31:0]   byte_mask;
    logic [31:0]   push_data;
    logic          fifo_full;
    logic          fifo_nempty;
    logic          bus_push;
    logic          bus_rd_pop;
    logic          do_flush;
    logic          do_clr;
    logic          do_scr;
    logic          do_pop;
    logic          do_push;
    logic          set_ovf;
    logic          unused_addr;

    // Only address bits [3:2] select a register
    assign unused_addr = ^{mem_addr[31:4], mem_addr[1:0]};

    // Request qualification and commit-cycle decode
    assign accept      = (state == ST_IDLE) && mem_valid && mem_myslot;
    assign commit      = (state == ST_ACK);
    assign req_wr      = |req_strb;
    assign byte_mask   = {{8{req_strb[3]}}, {8{req_strb[2]}}, {8{req_strb[1]}}, {8{req_strb[0]}}};
    assign push_data   = req_wdata & byte_mask;
    assign fifo_full   = (count == FULL_CNT);
    assign fifo_nempty = (count != '0);
    assign bus_push    = commit && (req_addr == A_DATA) && req_wr;
    assign bus_rd_pop  = commit && (req_addr == A_DATA) && !req_wr;
    assign do_flush    = commit && (req_addr == A_CTRL) && req_wr && req_wdata[1];
    assign do_clr      = commit && (req_addr == A_CTRL) && req_wr && req_wdata[0];
    assign do_scr      = commit && (req_addr == A_SCR) && req_wr;
    // Bus read and local pop share one pop; flush overrides any pop
    assign do_pop      = fifo_nempty && !do_flush && (bus_rd_pop || loc_pop);
    // A pop on the same edge frees the slot for a push into a full FIFO
    assign do_push     = bus_push && (!fifo_full || do_pop);
    assign set_ovf     = bus_push && fifo_full && !do_pop;

    // Head word straight from storage
    assign loc_data  = fifo_mem[rd_ptr];
    assign loc_count = count;

    // State register
    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // Next-state logic: accept, wait countdown, single ACK, hold until valid drops
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n    = ST_WAIT;
                    wait_cnt_n = 2'(WAIT_CLOCKS);
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_n = ST_ACK;
                end else begin
                    wait_cnt_n = wait_cnt - 2'd1;
                end
            end
            ST_ACK: begin
                state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (!mem_valid) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Next values of FIFO bookkeeping and registers
    always_comb begin
        count_n   = count;
        rd_ptr_n  = rd_ptr;
        wr_ptr_n  = wr_ptr;
        ovf_n     = ovf;
        scratch_n = scratch;
        if (do_flush) begin
            count_n  = '0;
            rd_ptr_n = '0;
            wr_ptr_n = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_n = rd_ptr + PW'(1);
            end
            if (do_push) begin
                wr_ptr_n = wr_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_n = count + CW'(1);
                2'b01:   count_n = count - CW'(1);
                default: count_n = count;
            endcase
        end
        if (set_ovf) begin
            ovf_n = 1'b1;
        end else if (do_clr) begin
            ovf_n = 1'b0;
        end
        if (do_scr) begin
            scratch_n = (scratch & ~byte_mask) | push_data;
        end
    end

`ifdef MAILBOX_IRQ_EN
    // Interrupt threshold follows any CONTROL write
    always_comb begin
        thresh_n = thresh;
        if (commit && (req_addr == A_CTRL) && req_wr) begin
            thresh_n = req_wdata[15:8];
        end
    end
`endif

    // Read data presented during ACK, taken from the state as of the ACK cycle
    always_comb begin
        rdata_d = 32'h0000_0000;
        if ((state_n == ST_ACK) && !req_wr) begin
            case (req_addr)
                A_DATA: begin
                    if (count_n != '0) begin
                        rdata_d = fifo_mem[rd_ptr_n];
                    end
                end
                A_STAT: begin
                    rdata_d = {ovf_n, (count_n == FULL_CNT), (count_n == '0), 21'h0, 8'(count_n)};
                end
                A_CTRL: begin
`ifdef MAILBOX_IRQ_EN
                    rdata_d = {16'h0000, thresh_n, 8'h00};
`else
                    rdata_d = 32'h0000_0000;
`endif
                end
                default: begin
                    rdata_d = scratch_n;
                end
            endcase
        end
    end

    // Request latch, FIFO bookkeeping and registered bus/local outputs
    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            req_addr    <= 2'd0;
            req_strb    <= 4'd0;
            req_wdata   <= 32'h0000_0000;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            scratch     <= SCRATCH_INIT;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= 32'h0000_0000;
            loc_empty   <= 1'b1;
        end else begin
            if (accept) begin
                req_addr  <= mem_addr[3:2];
                req_strb  <= mem_write;
                req_wdata <= mem_wdata;
            end
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr_n;
            count       <= count_n;
            ovf         <= ovf_n;
            scratch     <= scratch_n;
            mem_ready_o <= (state_n == ST_ACK);
            mem_rdata_o <= rdata_d;
            loc_empty   <= (count_n == '0);
        end
    end

    // Mailbox storage; contents are not reset
    always_ff @(posedge mem_clk) begin
        if (!mem_reset && do_push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

`ifdef MAILBOX_IRQ_EN
    // Interrupt tracks the occupancy threshold and sticky overflow
    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            thresh <= 8'd1;
            irq    <= 1'b0;
        end else begin
            thresh <= thresh_n;
            irq    <= ((8'(count_n) >= thresh_n) && (thresh_n != 8'd0)) || ovf_n;
        end
    end
`endif

endmodule

// File: tb/tb_nubus_mailbox_slave.sv
// Testbench for nubus_mailbox_slave: directed scenarios followed by random
// bus/local traffic, all checked against a queue-based mailbox model.
module tb_nubus_mailbox_slave;

    localparam int unsigned DEPTH       = 8;
    localparam int unsigned WAIT_CLOCKS = 1;
    localparam logic [31:0] SCR_INIT    = 32'hA5C3_0F1E;

    logic        mem_clk;
    logic        mem_reset;
    logic        mem_valid;
    logic [3:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_myslot;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        loc_pop;
    logic [31:0] loc_data;
    logic        loc_empty;
    logic [3:0]  loc_count;
`ifdef MAILBOX_IRQ_EN
    logic        irq;
`endif

    nubus_mailbox_slave #(
        .DEPTH       (DEPTH),
        .WAIT_CLOCKS (WAIT_CLOCKS),
        .SCRATCH_INIT(SCR_INIT)
    ) dut (
        .mem_clk    (mem_clk),
        .mem_reset  (mem_reset),
        .mem_valid  (mem_valid),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_myslot (mem_myslot),
        .mem_rdata_o(mem_rdata_o),
        .mem_ready_o(mem_ready_o),
        .loc_pop    (loc_pop),
        .loc_data   (loc_data),
        .loc_empty  (loc_empty),
        .loc_count  (loc_count)
`ifdef MAILBOX_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mailbox contents as a queue plus register values
    logic [31:0] mq[$];
    bit          m_ovf;
    logic [31:0] m_scr;
    int unsigned m_thresh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) m = m | (32'hFF << (8 * b));
        end
        return m;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] w;
        w = 32'(mq.size());
        if (m_ovf) w = w | 32'h8000_0000;
        if (mq.size() == DEPTH) w = w | 32'h4000_0000;
        if (mq.size() == 0) w = w | 32'h2000_0000;
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_scr    = SCR_INIT;
        m_thresh = 1;
    endtask

    // Compare the observable local-side state with the model
    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(loc_count), 32'(mq.size()));
        check({tag, "_empty"}, 32'(loc_empty), 32'(mq.size() == 0));
        if (mq.size() > 0) check({tag, "_head"}, loc_data, mq[0]);
        check({tag, "_rdata_idle"}, mem_rdata_o, 32'h0);
`ifdef MAILBOX_IRQ_EN
        check({tag, "_irq"}, 32'(irq),
              32'(((mq.size() >= m_thresh) && (m_thresh != 0)) || m_ovf));
`endif
    endtask

    // One full bus transaction; lpop raises loc_pop during the ACK cycle
    task automatic bus_xfer(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                            input bit lpop, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic [31:0] rnd;
        logic [31:0] m;
        int          lat;
        bit          pop_ok;
        exp_rd = 32'h0;
        if (s == 4'h0) begin
            case (a)
                2'd0: exp_rd = (mq.size() > 0) ? mq[0] : 32'h0;
                2'd1: exp_rd = model_status();
`ifdef MAILBOX_IRQ_EN
                2'd2: exp_rd = 32'(m_thresh) << 8;
`else
                2'd2: exp_rd = 32'h0;
`endif
                default: exp_rd = m_scr;
            endcase
        end
        lat = -1;
        rd  = 32'h0;
        @(negedge mem_clk);
        rnd        = $urandom();
        mem_valid  = 1'b1;
        mem_myslot = 1'b1;
        mem_write  = s;
        mem_wdata  = d;
        mem_addr   = {rnd[31:4], a, rnd[1:0]};
        for (int i = 0; i < 8; i++) begin
            @(negedge mem_clk);
            if (mem_ready_o) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'(WAIT_CLOCKS + 1));
        rd = mem_rdata_o;
        check("rdata", rd, exp_rd);
        loc_pop = lpop;
        @(negedge mem_clk);
        loc_pop = 1'b0;
        check("ready_one_cycle", 32'(mem_ready_o), 32'h0);
        repeat ($urandom_range(0, 2)) begin
            @(negedge mem_clk);
            check("no_reaccept", 32'(mem_ready_o), 32'h0);
        end
        mem_valid  = 1'b0;
        mem_myslot = 1'b0;
        mem_write  = 4'h0;
        // Model update
        pop_ok = lpop;
        m = lane_mask(s);
        if (a == 2'd0 && s != 4'h0) begin
            if (lpop && mq.size() > 0) void'(mq.pop_front());
            if (mq.size() < DEPTH) mq.push_back(d & m);
            else m_ovf = 1'b1;
        end else if (a == 2'd0) begin
            if (mq.size() > 0) void'(mq.pop_front());
        end else begin
            if (a == 2'd2 && s != 4'h0) begin
                if (d[1]) begin
                    mq.delete();
                    pop_ok = 1'b0;
                end
                if (d[0]) m_ovf = 1'b0;
`ifdef MAILBOX_IRQ_EN
                m_thresh = 32'(d[15:8]);
`endif
            end
            if (a == 2'd3 && s != 4'h0) m_scr = (m_scr & ~m) | (d & m);
            if (pop_ok && mq.size() > 0) void'(mq.pop_front());
        end
        check_state("xfer");
    endtask

    // One-cycle local pop outside any bus transaction
    task automatic loc_pop_step();
        @(negedge mem_clk);
        loc_pop = 1'b1;
        @(negedge mem_clk);
        loc_pop = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        check_state("lpop");
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic [3:0]  s;
        int          sel;
        mem_reset  = 1'b1;
        mem_valid  = 1'b0;
        mem_write  = 4'h0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_myslot = 1'b0;
        loc_pop    = 1'b0;
        model_reset();
        repeat (3) @(negedge mem_clk);
        check("reset_ready", 32'(mem_ready_o), 32'h0);
        mem_reset = 1'b0;
        check_state("reset");

        // STATUS right after reset
        bus_xfer(2'd1, 4'h0, 32'h0, 1'b0, rd);
        check("status_after_reset", rd, 32'h2000_0000);

        // Byte-strobed pushes, local pop, bus pop
        bus_xfer(2'd0, 4'hF, 32'h8765_4321, 1'b0, rd);
        bus_xfer(2'd0, 4'h3, 32'h8765_4321, 1'b0, rd);
        check("two_pushes_count", 32'(loc_count), 32'd2);
        check("head_full_word", loc_data, 32'h8765_4321);
        loc_pop_step();
        check("head_masked_word", loc_data, 32'h0000_4321);
        bus_xfer(2'd0, 4'h0, 32'h0, 1'b0, rd);
        check("bus_pop_masked", rd, 32'h0000_4321);
        check("empty_after_pop", 32'(loc_empty), 32'h1);

        // Overflow on DEPTH+1 pushes, then clear
        for (int i = 0; i <= DEPTH; i++) bus_xfer(2'd0, 4'hF, 32'(i), 1'b0, rd);
        bus_xfer(2'd1, 4'h0, 32'h0, 1'b0, rd);
        check("status_overflow", rd, 32'hC000_0008);
        bus_xfer(2'd2, 4'hF, 32'h0000_0001, 1'b0, rd);
        bus_xfer(2'd1, 4'h0, 32'h0, 1'b0, rd);
        check("status_ovf_cleared", rd, 32'h4000_0008);
        for (int i = 0; i < DEPTH; i++) begin
            bus_xfer(2'd0, 4'h0, 32'h0, 1'b0, rd);
            check("drain_order", rd, 32'(i));
        end
        bus_xfer(2'd0, 4'h0, 32'h0, 1'b0, rd);
        check("read_empty_zero", rd, 32'h0);
        bus_xfer(2'd1, 4'h0, 32'h0, 1'b0, rd);
        check("status_empty_no_ovf", rd, 32'h2000_0000);

        // Full FIFO: push coincident with local pop
        for (int i = 0; i < DEPTH; i++) bus_xfer(2'd0, 4'hF, 32'(100 + i), 1'b0, rd);
        bus_xfer(2'd0, 4'hF, 32'h0000_00AA, 1'b1, rd);
        bus_xfer(2'd1, 4'h0, 32'h0, 1'b0, rd);
        check("full_push_pop_status", rd, 32'h4000_0008);
        for (int i = 0; i < DEPTH; i++) bus_xfer(2'd0, 4'h0, 32'h0, 1'b0, rd);
        check("last_word_aa", rd, 32'h0000_00AA);

        // Other-slot requests are ignored
        @(negedge mem_clk);
        mem_valid  = 1'b1;
        mem_myslot = 1'b0;
        mem_write  = 4'hF;
        mem_addr   = 32'h0;
        repeat (4) begin
            @(negedge mem_clk);
            check("foreign_slot_ignored", 32'(mem_ready_o), 32'h0);
        end
        mem_valid = 1'b0;
        mem_write = 4'h0;
        check_state("foreign");

        // Scratch byte writes before reset
        bus_xfer(2'd3, 4'h5, 32'h1122_3344, 1'b0, rd);
        bus_xfer(2'd3, 4'h0, 32'h0, 1'b0, rd);
        check("scratch_bytes", rd, 32'hA522_0F44);

        // Reset during WAIT of a DATA write
        @(negedge mem_clk);
        mem_valid  = 1'b1;
        mem_myslot = 1'b1;
        mem_write  = 4'hF;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0000_0055;
        @(negedge mem_clk);
        mem_reset = 1'b1;
        @(negedge mem_clk);
        check("reset_mid_ready", 32'(mem_ready_o), 32'h0);
        mem_reset = 1'b0;
        mem_valid = 1'b0;
        mem_write = 4'h0;
        model_reset();
        repeat (4) begin
            @(negedge mem_clk);
            check("reset_mid_no_ready", 32'(mem_ready_o), 32'h0);
        end
        check_state("reset_mid");
        bus_xfer(2'd1, 4'h0, 32'h0, 1'b0, rd);
        check("status_after_mid_reset", rd, 32'h2000_0000);
        bus_xfer(2'd3, 4'h0, 32'h0, 1'b0, rd);
        check("scratch_reset_value", rd, SCR_INIT);

`ifdef MAILBOX_IRQ_EN
        // Threshold interrupt
        bus_xfer(2'd2, 4'hF, 32'h0000_0300, 1'b0, rd);
        bus_xfer(2'd0, 4'hF, 32'h1, 1'b0, rd);
        bus_xfer(2'd0, 4'hF, 32'h2, 1'b0, rd);
        check("irq_below_thresh", 32'(irq), 32'h0);
        bus_xfer(2'd0, 4'hF, 32'h3, 1'b0, rd);
        check("irq_at_thresh", 32'(irq), 32'h1);
        bus_xfer(2'd2, 4'h0, 32'h0, 1'b0, rd);
        check("ctrl_thresh_read", rd, 32'h0000_0300);
        bus_xfer(2'd2, 4'hF, 32'h0000_0302, 1'b0, rd);
        check("irq_after_flush", 32'(irq), 32'h0);
`else
        bus_xfer(2'd2, 4'hF, 32'h0000_0300, 1'b0, rd);
        bus_xfer(2'd2, 4'h0, 32'h0, 1'b0, rd);
        check("ctrl_reads_zero", rd, 32'h0);
`endif

        // Random traffic against the model
        repeat (300) begin
            sel = $urandom_range(0, 15);
            d   = $urandom();
            s   = 4'($urandom_range(1, 15));
            if (sel <= 6) begin
                bus_xfer(2'd0, s, d, bit'($urandom_range(0, 1)), rd);
            end else if (sel <= 10) begin
                bus_xfer(2'd0, 4'h0, 32'h0, bit'($urandom_range(0, 1)), rd);
            end else if (sel == 11) begin
                bus_xfer(2'd1, 4'h0, 32'h0, bit'($urandom_range(0, 1)), rd);
            end else if (sel == 12) begin
                d = (d & 32'h0000_0701) | (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
                if ($urandom_range(0, 1) == 0) s = 4'h0;
                bus_xfer(2'd2, s, d, bit'($urandom_range(0, 1)), rd);
            end else if (sel == 13) begin
                if ($urandom_range(0, 1) == 0) s = 4'h0;
                bus_xfer(2'd3, s, d, bit'($urandom_range(0, 1)), rd);
            end else begin
                loc_pop_step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nubus_mailbox_slave.md
Name: nubus_mailbox_slave

Overview:
Slave-side responder on the card's mem_* interface, the target end of the CPU→NuBus master→NuBus slave path. It decodes a 4-register window in the card's slot space and holds a DEPTH-word inbound FIFO mailbox. NuBus masters push words into the FIFO; local logic pops them. Responses use a programmable wait-state count and a one-cycle ready pulse.

Parameters:
DEPTH, 8, FIFO depth in 32-bit words; power of 2, range 2..64.
WAIT_CLOCKS, 1, number of wait cycles between request accept and mem_ready_o; range 0..3.
SCRATCH_INIT, 32'h0000_0000, reset value of the SCRATCH register.

Ports:
mem_clk  in  1  clock; all logic on rising edge.
mem_reset  in  1  reset, synchronous, active-high.
mem_valid  in  1  request valid from the NuBus slave engine.
mem_write  in  4  byte write strobes; 0 means read.
mem_addr  in  32  request address; only [3:2] decoded.
mem_wdata  in  32  write data.
mem_myslot  in  1  request targets this card's slot space.
mem_rdata_o  out  32  read data; valid while mem_ready_o=1.
mem_ready_o  out  1  one-cycle completion pulse.
loc_pop  in  1  local pop request.
loc_data  out  32  FIFO head word (combinational from storage).
loc_empty  out  1  FIFO empty.
loc_count  out  $clog2(DEPTH)+1  current occupancy.
irq  out  1  mailbox interrupt; present only with MAILBOX_IRQ_EN.

Behaviour:
- Register map by mem_addr[3:2]: 0 DATA (write pushes, read pops); 1 STATUS (read-only: [31] overflow sticky, [30] full, [29] empty, [7:0] count zero-extended); 2 CONTROL (write: bit0=1 clears overflow, bit1=1 flushes FIFO; reads return 0); 3 SCRATCH (byte-strobed read/write).
- FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE→WAIT on mem_valid & mem_myslot. Latch addr[3:2], strobes, wdata; load the wait counter with WAIT_CLOCKS.
  - WAIT decrements each cycle. At 0 it moves to ACK, so WAIT_CLOCKS=0 reaches ACK on the cycle after accept.
  - ACK: mem_ready_o=1 for exactly one cycle. The register side effect (push/pop/clear/flush/scratch write) commits on this edge. Then go to HOLD.
  - HOLD→IDLE once mem_valid=0. A new request cannot be accepted until mem_valid has been seen low.
- Latency: accept edge to mem_ready_o = WAIT_CLOCKS+1 cycles.
- mem_valid & ~mem_myslot: ignored; stay in IDLE.
- DATA write:
  - Pushes the word with unstrobed lanes forced to 0.
  - Push while full: data dropped, overflow set, count unchanged. Ready still pulses.
- DATA read:
  - Returns the head and pops in ACK.
  - Read while empty returns 32'h0000_0000, does not pop, and does not set overflow.
- Local pop:
  - loc_pop while empty is ignored.
  - loc_pop and a bus DATA read in the same ACK cycle: the bus wins, only one word is popped, and loc_pop is dropped for that cycle.
- Simultaneous bus push and loc_pop: both occur and count is unchanged. When full, the pop frees the slot, so no overflow.
- Flush: count=0 and pointers reset. If a local pop occurs on the same edge, the flush wins.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- mem_rdata_o is 0 whenever mem_ready_o=0.
- Reset values (synchronous, forces IDLE mid-transaction, no commit):
  - mem_ready_o=0, mem_rdata_o=0.
  - count=0, loc_empty=1, loc_count=0, overflow=0.
  - SCRATCH=SCRATCH_INIT, irq=0.
  - FIFO storage contents undefined.

Optional Feature:
MAILBOX_IRQ_EN
- Defined:
  - Port irq and a CONTROL field [15:8] IRQ_THRESH (reset 1) are added.
  - irq is registered and equals (count ≥ IRQ_THRESH && IRQ_THRESH≠0) | overflow.
  - CONTROL reads return IRQ_THRESH in [15:8].
- Undefined: no irq port; CONTROL [15:8] is ignored on write and reads as 0.

Test Plan:
- Reset, then read STATUS (addr 0x4), WAIT_CLOCKS=1 → ready 2 cycles after accept, rdata=32'h2000_0000.
- Write DATA strobe 4'b1111 data 32'h8765_4321, then strobe 4'b0011 data 32'h8765_4321 → loc_count=2. loc_data=32'h8765_4321; after loc_pop, loc_data=32'h0000_4321. Bus read DATA → 32'h0000_4321, loc_empty=1.
- Push DEPTH+1 words (0..8, DEPTH=8) → STATUS=32'hC000_0008, word 8 absent. CONTROL write 1 → STATUS=32'h4000_0008.
- FIFO full, bus DATA write 0xAA coincident with loc_pop in ACK → overflow stays 0, count stays 8, the last word read is 0xAA.
- Assert mem_reset during WAIT of a DATA write → no push, mem_ready_o never pulses, next STATUS read returns 32'h2000_0000.
- MAILBOX_IRQ_EN build: CONTROL write 32'h0000_0300, push 2 words → irq=0; push 3rd → irq=1 one cycle after ACK. Flush (CONTROL write 32'h0000_0302) → irq=0.
